// File: rtl/tristate_bus_arbiter_pkg.sv
// tristate_bus_arbiter_pkg: state encodings and width helper shared by the arbiter files
package tristate_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURNAROUND = 2'd2} state_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// tristate_bus_arbiter_if: request/grant bundle between requesters and the arbiter
// req: level requests; gnt: one-hot-or-zero tri-state enables; owner: current/last grantee; bus_z: bus floating
interface tristate_bus_arbiter_if import tristate_bus_arbiter_pkg::*; #(parameter int N = 4) ();
  localparam int W = clog2(N);
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [W-1:0] owner;
  logic bus_z;
  modport master (input req, output gnt, owner, bus_z);
  modport slave (output req, input gnt, owner, bus_z);
endinterface

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// rr_pick: round-robin winner search starting just above the current owner
// req: requests; owner: lowest-priority index; idx: winner (owner when none); valid: any request
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] owner,
  output logic [W-1:0] idx,
  output logic         valid
);
  logic [W-1:0] c;
  // scan from the farthest offset down so the nearest set bit above owner wins last
  always_comb begin
    idx = owner;
    c = '0;
    for (int i = N; i >= 1; i--) begin
      c = W'((int'(owner) + i) % N);
      if (req[c]) idx = c;
    end
  end
  assign valid = |req;
endmodule

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin tri-state enable arbiter with turnaround gap and hold timeout
// clk/rst: clock and async active-high reset; bus.req in; bus.gnt/owner/bus_z registered out
module tristate_bus_arbiter import tristate_bus_arbiter_pkg::*; #(
  parameter int N = 4,
  parameter int TURN = 1,
  parameter int MAX_HOLD = 16
) (
  input logic clk,
  input logic rst,
  tristate_bus_arbiter_if.master bus
);
  localparam int W = clog2(N);
  localparam int HW = clog2(MAX_HOLD + 1);
  localparam int TW = clog2(TURN + 1);
  state_t state, state_n;
  logic [N-1:0] gnt, gnt_n;
  logic [W-1:0] owner, owner_n, pick;
  logic [HW-1:0] hold, hold_n;
  logic [TW-1:0] turn, turn_n;
  logic bus_z, pick_valid, pick_now, rel, preempt;
  rr_pick #(.N(N), .W(W)) u_pick (.req(bus.req), .owner(owner), .idx(pick), .valid(pick_valid));
  assign rel = !bus.req[owner];
  assign preempt = hold == HW'(MAX_HOLD) && |(bus.req & ~(N'(1) << owner));
  // selection happens in IDLE and on the last turnaround cycle; the unused encoding behaves as IDLE
  assign pick_now = state != GRANT && (state != TURNAROUND || turn == TW'(TURN));
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    owner_n = owner;
    hold_n = hold;
    turn_n = turn;
    if (state == GRANT) begin
      if (rel || preempt) begin
        state_n = TURNAROUND;
        gnt_n = '0;
        turn_n = TW'(1);
      end else if (hold != HW'(MAX_HOLD)) hold_n = hold + HW'(1);
    end else if (pick_now) begin
      state_n = pick_valid ? GRANT : IDLE;
      gnt_n = pick_valid ? N'(1) << pick : '0;
      owner_n = pick_valid ? pick : owner;
      hold_n = pick_valid ? HW'(1) : '0;
      turn_n = '0;
    end else turn_n = turn + TW'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      owner <= W'(N - 1);
      hold <= '0;
      turn <= '0;
      bus_z <= 1'b1;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      owner <= owner_n;
      hold <= hold_n;
      turn <= turn_n;
      bus_z <= gnt_n == '0;
    end
  end
  assign bus.gnt = gnt;
  assign bus.owner = owner;
  assign bus.bus_z = bus_z;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb_tristate_bus_arbiter: model-checked bench for TURN=1 and TURN=3 arbiters sharing one request vector
module tb_tristate_bus_arbiter;
  import tristate_bus_arbiter_pkg::*;
  localparam int N = 4;
  localparam int W = clog2(N);
  localparam int MAX_HOLD = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  tristate_bus_arbiter_if #(.N(N)) b1 ();
  tristate_bus_arbiter_if #(.N(N)) b3 ();
  assign b1.req = req;
  assign b3.req = req;
  tristate_bus_arbiter #(.N(N), .TURN(1), .MAX_HOLD(MAX_HOLD)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  tristate_bus_arbiter #(.N(N), .TURN(3), .MAX_HOLD(MAX_HOLD)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  // model: index 0 mirrors the TURN=1 instance, index 1 the TURN=3 instance
  bit m_busy[2];
  logic [W-1:0] m_owner[2];
  int m_hold[2];
  int m_gap[2];
  function automatic int turn_of(input int i);
    return i == 0 ? 1 : 3;
  endfunction
  function automatic logic [W-1:0] rr_winner(input logic [W-1:0] last, input logic [N-1:0] r);
    logic [W-1:0] c;
    for (int k = 1; k <= N; k++) begin
      c = W'((int'(last) + k) % N);
      if (r[c]) return c;
    end
    return last;
  endfunction
  function automatic logic [N-1:0] exp_gnt(input int i);
    return m_busy[i] ? N'(1) << m_owner[i] : '0;
  endfunction
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] <= 1'b0;
        m_owner[i] <= W'(N - 1);
        m_hold[i] <= 0;
        m_gap[i] <= 0;
      end else if (m_busy[i]) begin
        if (!req[m_owner[i]] || (m_hold[i] >= MAX_HOLD && (req & ~(N'(1) << m_owner[i])) != '0)) begin
          m_busy[i] <= 1'b0;
          m_gap[i] <= turn_of(i);
        end else m_hold[i] <= (m_hold[i] < MAX_HOLD) ? m_hold[i] + 1 : MAX_HOLD;
      end else if (m_gap[i] > 1) m_gap[i] <= m_gap[i] - 1;
      else begin
        m_gap[i] <= 0;
        if (req != '0) begin
          m_busy[i] <= 1'b1;
          m_owner[i] <= rr_winner(m_owner[i], req);
          m_hold[i] <= 1;
        end
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_t1", b1.gnt, exp_gnt(0));
      chk("owner_t1", b1.owner, m_owner[0]);
      chk("bus_z_t1", b1.bus_z, !m_busy[0]);
      chk("onehot_t1", int'($onehot0(b1.gnt)), 1);
      chk("gnt_t3", b3.gnt, exp_gnt(1));
      chk("owner_t3", b3.owner, m_owner[1]);
      chk("bus_z_t3", b3.bus_z, !m_busy[1]);
      chk("onehot_t3", int'($onehot0(b3.gnt)), 1);
    end
  end
  initial begin
    int c, z;
    int rr[5] = '{0, 1, 2, 3, 0};
    tick(2);
    chk("rst_gnt", b1.gnt, 0);
    chk("rst_bus_z", b1.bus_z, 1);
    chk("rst_owner", b1.owner, 3);
    rst = 1'b0;
    req = 4'b0100;
    tick(1);
    chk("single_gnt_t1", b1.gnt, 4'b0100);
    chk("single_gnt_t3", b3.gnt, 4'b0100);
    tick(40);
    chk("single_hold_t1", b1.gnt, 4'b0100);
    chk("single_hold_t3", b3.gnt, 4'b0100);
    req = '0;
    tick(1);
    chk("single_drop", b1.gnt, 0);
    tick(4);
    chk("single_idle", b1.bus_z, 1);
    req = 4'b0010;
    tick(2);
    chk("pre_rst_gnt", b1.gnt, 4'b0010);
    #2 rst = 1'b1;
    #1;
    chk("async_gnt_t1", b1.gnt, 0);
    chk("async_bus_z_t1", b1.bus_z, 1);
    chk("async_gnt_t3", b3.gnt, 0);
    tick(1);
    req = 4'b1111;
    rst = 1'b0;
    tick(1);
    chk("first_after_rst_t1", b1.gnt, 4'b0001);
    chk("first_after_rst_t3", b3.gnt, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      z = 0;
      while (b1.gnt == '0 && z < 20) begin
        z++;
        tick(1);
      end
      if (i > 0) chk("rr_gap", z, 1);
      chk("rr_order", b1.gnt, 1 << rr[i]);
      tick(2);
      req[rr[i]] = 1'b0;
      tick(1);
      chk("rr_release", b1.gnt, 0);
      req[rr[i]] = 1'b1;
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req = 4'b0011;
    tick(1);
    chk("preempt_first", b1.gnt, 4'b0001);
    c = 0;
    while (b1.gnt == 4'b0001 && c < 40) begin
      c++;
      tick(1);
    end
    chk("preempt_len0", c, 16);
    z = 0;
    while (b1.gnt == '0 && z < 10) begin
      z++;
      tick(1);
    end
    chk("preempt_gap", z, 1);
    chk("preempt_next", b1.gnt, 4'b0010);
    c = 0;
    while (b1.gnt == 4'b0010 && c < 40) begin
      c++;
      tick(1);
    end
    chk("preempt_len1", c, 16);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req = 4'b0010;
    tick(1);
    chk("ta_owner1", b3.gnt, 4'b0010);
    req = 4'b0100;
    tick(1);
    z = 0;
    while (b3.gnt == '0 && z < 10) begin
      chk("ta_bus_z", b3.bus_z, 1);
      z++;
      tick(1);
    end
    chk("ta_len", z, 3);
    chk("ta_next", b3.gnt, 4'b0100);
    for (int i = 0; i < 10000; i++) begin
      req = N'($urandom_range(0, 15));
      tick(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Round-robin arbiter for a shared tri-state bus: N requesters each drive the bus through their own `t ? i : 1'bz` buffer, and this block decides which `t` is high. It guarantees at most one enable is active. It inserts a configurable all-Z turnaround gap between owners so drivers never overlap. A hold timeout stops one requester from starving the others. It sits beside the tri-state drivers in the tutorial designs and supplies their enable lines.

## Interface
- `N`, 4: number of requesters (2..8).
- `TURN`, 1: turnaround cycles with bus released (Z) between owners (>=1).
- `MAX_HOLD`, 16: max consecutive grant cycles while another requester waits (>=2).
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input N: level requests; bit k high while requester k wants the bus.
- `gnt` output N: one-hot or zero grant; bit k is requester k's tri-state enable `t`.
- `owner` output clog2(N): index of current grantee; holds last owner when `gnt`==0.
- `bus_z` output 1: high when `gnt`==0, so the bus floats (Z).

## Operation
- States: IDLE, GRANT, TURNAROUND.
- IDLE:
  - `gnt`=0.
  - If `req`!=0, pick the winner and go to GRANT. The winning `gnt` bit rises the next cycle.
- Winner selection is round robin:
  - Pick the first set `req` bit scanning upward from `owner`+1, wrapping at N-1 -> 0.
  - The current owner is the lowest priority.
- GRANT:
  - `gnt`[owner]=1.
  - A hold counter counts grant cycles, starting at 1 in the first grant cycle.
- GRANT -> TURNAROUND when either of these holds:
  - `req`[owner]==0 (voluntary release), or
  - the hold counter == MAX_HOLD and any other `req` bit is set (preemption).
- If no other requester waits, the owner keeps the bus indefinitely. The hold counter saturates at MAX_HOLD.
- TURNAROUND:
  - `gnt`=0 for exactly TURN cycles, counted by the turnaround counter.
  - After the last cycle: if `req`!=0, run winner selection and go to GRANT; else go to IDLE.
  - `req` is sampled on the last TURNAROUND cycle.
- A preempted owner still holding `req` re-competes at lowest priority.
- A requester dropping `req` while not granted simply loses eligibility. There is no latching of past requests.
- `req` bits above N-1 do not exist. `owner` never exceeds N-1.

## Timing
- Reset values: state IDLE, `gnt`=0, `bus_z`=1, `owner`=N-1 (so requester 0 wins first), counters 0.
- Request-to-grant latency:
  - From IDLE: 1 cycle (`req` sampled at edge k, `gnt` high after edge k).
  - From TURNAROUND: TURN cycles after the release edge.
- Release-to-next-grant: `gnt` falls on the edge after `req`[owner] is seen low. The next `gnt` rises TURN edges later.
- Never two `gnt` bits high in any cycle. Never a new `gnt` in the cycle an old one falls.
- All outputs are registered. There are no combinational paths from `req` to `gnt` or `bus_z`.
- Simultaneous release and preemption condition: treated as a single transition to TURNAROUND.
- `rst` asserted mid-grant: `gnt` goes to 0 immediately (asynchronously), so the bus floats at once. After deassert the block restarts in IDLE with `owner`=N-1.

## Structure
- Shared include or package holds the state encodings (IDLE=2'd0, GRANT=2'd1, TURNAROUND=2'd2) and the `clog2` width helper.
- One sub-module is natural: `rr_pick`. It is combinational and takes `req` and `owner`, returning next index and valid. This keeps the priority rotation testable alone.
- Counters (hold, turnaround) and the FSM stay in the top module.

## Test plan
- Reset: `rst`=1 mid-grant with `req`=4'b0010 -> `gnt` drops to 0 asynchronously and `bus_z`=1. After release with `req`=4'b1111, first `gnt`=4'b0001.
- Single requester: `req`=4'b0100 from IDLE -> `gnt`=4'b0100 one cycle later. Hold `req` 40 cycles -> `gnt` stays (no preemption). Drop `req` -> `gnt`=0 the next cycle, then IDLE.
- Round robin with TURN=1: `req`=4'b1111, each owner drops `req` after 3 cycles then reasserts -> grant order 0,1,2,3,0. Exactly one `gnt`=0 cycle between owners.
- Preemption with MAX_HOLD=16: `req`=4'b0011 held constantly -> 16-cycle grant to 0, 1 Z cycle, 16-cycle grant to 1, and so on.
- Turnaround length with TURN=3: owner 1 releases while `req`[2]=1 -> exactly 3 cycles `gnt`=0 and `bus_z`=1, then `gnt`=4'b0100.
- Contention check: a bench models the bus with `assign bus = gnt[k] ? d[k] : 1'bz` for all k, drives random `req` for 10k cycles -> bus never X, and `$onehot0(gnt)` holds throughout.
